// File: rtl/seq_shift_add_mult.sv
// Iterative 32x32 unsigned shift-and-add multiplier producing a 64-bit product.
// One 32-bit carry-lookahead adder performs every partial-product accumulate.

module seq_shift_add_mult_cla (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] s_o,
    output logic        cout_o
);
    localparam int unsigned NGRP = 8;

    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic        c_grp;
    logic        g_grp;
    logic        p_grp;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // 4-bit lookahead groups; group generate/propagate chain the groups together
    always_comb begin
        c     = '0;
        c_grp = cin_i;
        g_grp = 1'b0;
        p_grp = 1'b0;
        for (int k = 0; k < NGRP; k++) begin
            c[4*k]   = c_grp;
            c[4*k+1] = g[4*k] | (p[4*k] & c_grp);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & c_grp);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c_grp);
            g_grp    = g[4*k+3] | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            p_grp    = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
            c_grp    = g_grp | (p_grp & c_grp);
        end
    end

    assign s_o    = p ^ c;
    assign cout_o = c_grp;
endmodule

module seq_shift_add_mult #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  a,
    input  logic [31:0]  b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  product,
    output logic         hi_nz,
    output logic         busy
);
    localparam int unsigned DW = 32;

    if (WIDTH != DW) begin : g_bad_width
        $error("seq_shift_add_mult: WIDTH must equal the CLA width (32)");
    end
    if ((64'd1 << CNT_W) <= 64'(WIDTH)) begin : g_bad_cnt_w
        $error("seq_shift_add_mult: CNT_W too narrow to hold WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    mcand_q, mcand_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [DW-1:0]    mplier_q, mplier_d;
    logic             in_ready_q, busy_q, out_valid_q, hi_nz_q;

    logic [DW-1:0]    cla_b;
    logic [DW-1:0]    cla_s;
    logic             cla_cout;

    assign cla_b = mplier_q[0] ? mcand_q : '0;

    seq_shift_add_mult_cla u_cla (
        .a_i    (acc_q),
        .b_i    (cla_b),
        .cin_i  (1'b0),
        .s_o    (cla_s),
        .cout_o (cla_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            acc_q       <= '0;
            mplier_q    <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            hi_nz_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            mplier_q    <= mplier_d;
            in_ready_q  <= (state_d == IDLE);
            busy_q      <= (state_d == COMPUTE);
            out_valid_q <= (state_d == DONE);
            hi_nz_q     <= |acc_d;
        end
    end

    // Carry-out enters the accumulator MSB as the pair shifts right
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = a;
                    acc_d    = '0;
                    mplier_d = b;
                    cnt_d    = '0;
                    state_d  = COMPUTE;
                end
            end
            COMPUTE: begin
                acc_d    = {cla_cout, cla_s[DW-1:1]};
                mplier_d = {cla_s[0], mplier_q[DW-1:1]};
                cnt_d    = CNT_W'(cnt_q + CNT_W'(1));
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign hi_nz     = hi_nz_q;
    assign product   = {acc_q, mplier_q};
endmodule

// File: doc/seq_shift_add_mult.md
Name: seq_shift_add_mult

Overview:
- Iterative 32x32 unsigned multiplier that produces a 64-bit product.
- Sits directly downstream of the 32-bit carry-lookahead adder and consumes its sum/carry once per cycle for the partial-product accumulate.
- Instantiates exactly one CLA (A, B, Cin, S, Cout) as its only adder; no behavioural "+" or "*" on the datapath.
- Fixed 32-cycle latency; valid/ready handshake on both input and output.

Parameters:
- WIDTH, 32, operand width. Fixed by the CLA width; any other value is unsupported and must fail elaboration.
- CNT_W, 6, width of the iteration counter. It must be able to hold the value WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a/b are valid
- in_ready  output  1  block can accept operands; high only in IDLE
- a  input  32  multiplicand, unsigned
- b  input  32  multiplier, unsigned
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  64  a*b, unsigned
- hi_nz  output  1  product[63:32] != 0, i.e. the result does not fit in 32 bits
- busy  output  1  high in COMPUTE

Behaviour:
- Reset (rst=1 at a clk edge, in any state including mid-COMPUTE):
  - state <= IDLE, counter <= 0, internal registers <= 0.
  - After that edge: out_valid=0, product=0, hi_nz=0, busy=0, in_ready=1.
  - A partially computed result is discarded and is never presented.
- States: IDLE, COMPUTE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1: latch mcand<=a, acc[32:0]<=0, mplier<=b, cnt<=0; go to COMPUTE.
  - No other action.
- COMPUTE (in_ready=0, busy=1):
  - CLA inputs: A=acc[31:0], B=(mplier[0] ? mcand : 0), Cin=0.
  - Each edge: {acc, mplier} <= {1'b0, Cout, S, mplier[31:1]} shifted right by one, i.e.:
    - new acc[32:0] = {1'b0, Cout, S[31:1]}
    - new mplier = {S[0], mplier[31:1]}
  - cnt <= cnt+1.
  - When cnt==31 at an edge: that edge performs the last iteration and state <= DONE.
  - Exactly 32 iterations per operation.
- DONE:
  - out_valid=1, product={acc[31:0], mplier}, hi_nz=|acc[31:0].
  - Outputs held stable while out_ready=0, for any number of cycles.
  - On out_ready=1: go to IDLE and drop out_valid.
  - The next operand is not accepted in that same cycle.
- Latency and throughput:
  - Accept edge E0; out_valid is high from edge E32 onward (32 cycles).
  - Minimum issue interval 34 cycles (accept, 32 compute edges, output handshake edge).
- in_valid while in_ready=0: ignored; the operands on a/b are not sampled.
- product and hi_nz are don't-care while out_valid=0 but must be deterministic; they are driven from the internal registers.
- Overflow: impossible. The 32-bit acc plus the CLA carry-out covers the full 64-bit range. Cout must never be dropped.
- Operand a or b == 0: still takes the full 32 cycles; result 0, hi_nz=0. There is no early termination.
- Simultaneous rst and in_valid: rst wins; nothing is accepted.

Test Plan:
- Reset then a=3, b=5, in_valid for one cycle:
  - in_ready drops the next cycle and busy=1 for 32 cycles.
  - out_valid rises exactly 32 cycles after the accept edge.
  - product=64'h0000_0000_0000_000F, hi_nz=0.
- a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001, hi_nz=1. This exercises the CLA Cout on every iteration.
- a=32'h8000_0000, b=2 -> product=64'h0000_0001_0000_0000, hi_nz=1.
- a=0, b=32'h1234_5678 -> product=0 after 32 cycles, hi_nz=0.
- Backpressure:
  - a=7, b=6, out_ready=0 for 10 cycles after out_valid -> product stays 42 and out_valid stays 1 throughout.
  - in_valid pulsed with a=9 during COMPUTE is ignored.
  - Raising out_ready returns to IDLE next edge, and in_ready=1.
- Reset mid-operation:
  - Start a=100, b=200; assert rst at compute cycle 15 -> next edge out_valid=0, in_ready=1, product=0.
  - A new a=2, b=3 then completes with product=6 after 32 cycles.
- Random regression: 1000 random a/b pairs with random out_ready stalls -> every product equals a 64-bit reference multiply, and exactly one output handshake per accepted input.
